lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Memory-stage load/store controller that replaces the purely combinational byte-enable/exception logic with a handshaked, multi-cycle bus master. It sits between the M-stage pipeline register and the data bus (DM plus timer devices). It checks the access against alignment and the address map, generates byte lanes for any power-of-two data width, waits on a req/ack bus, and extends load data. It stalls the pipeline until the access completes or faults.

## Interface
- DATA_W, 32, bus data width; 32 or 64
- ADDR_W, 32, address width
- DM_LIMIT, 32'h0000_2FFF, last DM byte address; DM spans 0..DM_LIMIT
- DEV0_BASE, 32'h0000_7F00, timer 0 window base, 12 bytes
- DEV1_BASE, 32'h0000_7F10, timer 1 window base, 12 bytes
- TIMEOUT_CYC, 15, bus-ack timeout in cycles (used only with LSU_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  M stage holds a load or store; held stable while stall=1
- req_store  in  1  1=store, 0=load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_sign  in  1  sign-extend load data
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- req_ovf  in  1  address-add overflow from the ALU
- flush  in  1  interrupt/exception kill of the M-stage instruction
- stall  out  1  freeze the pipeline
- rsp_valid  out  1  access finished this cycle
- rsp_rdata  out  DATA_W  extended load data
- exc_adel / exc_ades  out  1  load / store address exception, valid with rsp_valid
- bus_req, bus_we  out  1  bus request, write enable
- bus_addr  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero)
- bus_be  out  DATA_W/8  byte enables
- bus_wdata  out  DATA_W  lane-shifted store data
- bus_ack  in  1  completes the request in this cycle
- bus_rdata  in  DATA_W  valid with bus_ack

## Operation
- FSM: IDLE, BUSY, DONE. Reset: IDLE; all outputs 0.
- IDLE, req_valid & !flush: request is accepted and fault-checked. A fault loads the exception flag and goes to DONE. Otherwise bus_* registers load and the FSM goes to BUSY.
- Fault set, any true:
  - addr not a multiple of the size in bytes;
  - req_size=3 with DATA_W=32;
  - req_ovf;
  - addr outside DM and both device windows;
  - size below word inside a device window;
  - store to device offset 8..11 (read-only count register).
- Load faults raise exc_adel; store faults raise exc_ades.
- Lanes: off = addr low bits, n = 1<<size. bus_be = ((1<<n)-1)<<off; bus_wdata = req_wdata<<(8*off).
- Load data: (bus_rdata>>(8*off)) truncated to n bytes, then zero- or sign-extended to DATA_W. Captured on bus_ack.
- BUSY: bus_req stays high with stable bus_* until bus_ack; on bus_ack → DONE.
- DONE: rsp_valid=1 for one cycle → IDLE.
- stall = req_valid & (state≠DONE) & !flush.
- flush in BUSY sets kill. The bus transaction still completes; it is never aborted. On ack → IDLE with no rsp_valid.
- flush in DONE gates rsp_valid and the exc outputs to 0.
- reset mid-BUSY drops bus_req immediately.

## Timing
- Accepted in cycle 0, bus_req high in cycle 1. With ack in cycle k, rsp_valid is high in cycle k+1. Minimum latency is 2 cycles.
- Fault: rsp_valid and exc high in cycle 1, with no bus cycle.
- Back-to-back: a new accept is possible in the cycle after DONE.

## Configuration
- LSU_TIMEOUT_EN defined: a counter clears on entering BUSY. After TIMEOUT_CYC BUSY cycles without ack, bus_req drops and the FSM goes to DONE with exc_adel (load) or exc_ades (store).
- LSU_TIMEOUT_EN undefined: BUSY waits indefinitely and the counter is absent.

## Structure
- lsu_pkg:
  - size encodings;
  - FSM state enum;
  - DM/device address-map defaults;
  - device window span (12) and read-only offset (8).
- One sub-module, lsu_lane: combinational be/wdata alignment plus load extract/extend, parametrised by DATA_W.

## Test plan
- DATA_W=32, sh 0x1234 at 0x0000_0102, ack in cycle 3:
  - bus_be=4'b1100, bus_wdata=0x1234_0000 in cycles 1..3;
  - rsp_valid in cycle 4, no exception.
- DATA_W=64, lb sign at 0x0000_0007, bus_rdata byte 7 = 0x80:
  - bus_be=8'h80;
  - rsp_rdata=64'hFFFF_FFFF_FFFF_FF80.
- lw at 0x0000_0002 → exc_adel in cycle 1, bus_req never asserted.
- Device windows:
  - sw to 0x0000_7F08 → exc_ades;
  - lh to 0x0000_7F00 → exc_adel;
  - lw to 0x0000_7F08 → normal bus read.
- flush in cycle 2 of BUSY:
  - stall drops immediately;
  - ack is accepted later;
  - rsp_valid stays 0.
- LSU_TIMEOUT_EN, sw with no ack:
  - bus_req falls after 15 BUSY cycles;
  - exc_ades together with rsp_valid.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// lsu_bus_ctrl_pkg: access sizes, FSM states and default address map shared by lsu_bus_ctrl
package lsu_bus_ctrl_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_2FFF;
  localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;
  localparam int DEV_SPAN = 12;
  localparam int DEV_RO_OFF = 8;
  function automatic logic [3:0] size_bytes(input size_e s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: pipeline request/response and data-bus signals of lsu_bus_ctrl
interface lsu_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic req_valid, req_store, req_sign, req_ovf, flush;
  logic [1:0] req_size;
  logic [ADDR_W-1:0] req_addr, bus_addr;
  logic [DATA_W-1:0] req_wdata, rsp_rdata, bus_wdata, bus_rdata;
  logic stall, rsp_valid, exc_adel, exc_ades;
  logic bus_req, bus_we, bus_ack;
  logic [DATA_W/8-1:0] bus_be;
  modport master (
    input req_valid, req_store, req_sign, req_ovf, flush, req_size, req_addr, req_wdata,
    input bus_ack, bus_rdata,
    output stall, rsp_valid, rsp_rdata, exc_adel, exc_ades,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
  modport slave (
    output req_valid, req_store, req_sign, req_ovf, flush, req_size, req_addr, req_wdata,
    output bus_ack, bus_rdata,
    input stall, rsp_valid, rsp_rdata, exc_adel, exc_ades,
    input bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_bus_ctrl_lane.sv
// lsu_bus_ctrl_lane: byte-lane enables, store data alignment and load extract/extend
module lsu_bus_ctrl_lane #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                     size_i,
  input  logic [$clog2(DATA_W/8)-1:0]    off_i,
  input  logic                           sign_i,
  input  logic [DATA_W-1:0]              wdata_i,
  input  logic [DATA_W-1:0]              rdata_i,
  output logic [DATA_W/8-1:0]            be_o,
  output logic [DATA_W-1:0]              wdata_o,
  output logic [DATA_W-1:0]              rdata_o
);
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(DATA_W);
  logic [NB-1:0] ones;
  logic [3:0] nbytes;
  logic [BW-1:0] msb_idx;
  logic [DATA_W-1:0] shr;
  assign ones = '1;
  assign nbytes = 4'd1 << size_i;
  assign be_o = ~(ones << nbytes) << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign msb_idx = BW'((8 << size_i) - 1);
  always_comb begin
    shr = rdata_i >> {off_i, 3'b000};
    for (int i = 0; i < DATA_W; i++) rdata_o[i] = (i < (8 << size_i)) ? shr[i] : sign_i & shr[msb_idx];
  end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: handshaked M-stage load/store bus master with alignment/address-map faults.
// Define LSU_TIMEOUT_EN to abort BUSY with an address exception after TIMEOUT_CYC cycles without ack.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] DM_LIMIT = ADDR_W'(DM_LIMIT_DEF),
  parameter logic [ADDR_W-1:0] DEV0_BASE = ADDR_W'(DEV0_BASE_DEF),
  parameter logic [ADDR_W-1:0] DEV1_BASE = ADDR_W'(DEV1_BASE_DEF)
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 15
`endif
) (
  input logic clk,
  input logic reset,
  lsu_bus_ctrl_if.master io
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  state_e state_q, state_d;
  logic kill_q, kill_d, exc_q, exc_d, store_q, sign_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q, off0, off1;
  logic [DATA_W-1:0] wdata_q, rdata_q, lane_wdata, lane_rdata;
  logic [NB-1:0] lane_be;
  logic [3:0] nbytes;
  logic in_dm, in_dev0, in_dev1, ro_hit, fault, accept, busy, done, ack, tmo;
  assign off0 = io.req_addr - DEV0_BASE;
  assign off1 = io.req_addr - DEV1_BASE;
  assign in_dm = io.req_addr <= DM_LIMIT;
  // unsigned offsets wrap below the base, so one compare bounds each window
  assign in_dev0 = off0 < ADDR_W'(DEV_SPAN);
  assign in_dev1 = off1 < ADDR_W'(DEV_SPAN);
  assign ro_hit = (in_dev0 && off0 >= ADDR_W'(DEV_RO_OFF)) || (in_dev1 && off1 >= ADDR_W'(DEV_RO_OFF));
  assign nbytes = size_bytes(size_e'(io.req_size));
  assign fault = |(io.req_addr[3:0] & (nbytes - 4'd1))
              || (DATA_W < 64 && io.req_size == SZ_D)
              || io.req_ovf
              || !(in_dm || in_dev0 || in_dev1)
              || ((in_dev0 || in_dev1) && io.req_size < SZ_W)
              || (io.req_store && ro_hit);
  assign accept = state_q == IDLE && io.req_valid && !io.flush;
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign ack = busy && io.bus_ack;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = busy && !io.bus_ack && cnt_q == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      kill_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q <= kill_d;
      exc_q <= exc_d;
    end
  // a flushed bus access still runs to its ack, then retires silently
  always_comb begin
    state_d = state_q;
    kill_d = kill_q;
    exc_d = exc_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = fault ? DONE : BUSY;
        kill_d = 1'b0;
        exc_d = fault;
      end
      BUSY: begin
        kill_d = kill_q | io.flush;
        if (io.bus_ack || tmo) begin
          state_d = kill_d ? IDLE : DONE;
          exc_d = tmo;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      store_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        store_q <= io.req_store;
        sign_q <= io.req_sign;
        size_q <= io.req_size;
        addr_q <= io.req_addr;
        wdata_q <= io.req_wdata;
      end
      if (ack) rdata_q <= lane_rdata;
    end
  lsu_bus_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
    .size_i (size_q),
    .off_i  (addr_q[OW-1:0]),
    .sign_i (sign_q),
    .wdata_i(wdata_q),
    .rdata_i(io.bus_rdata),
    .be_o   (lane_be),
    .wdata_o(lane_wdata),
    .rdata_o(lane_rdata)
  );
  assign io.stall = io.req_valid && !done && !io.flush;
  assign io.rsp_valid = done && !io.flush;
  assign io.exc_adel = io.rsp_valid && exc_q && !store_q;
  assign io.exc_ades = io.rsp_valid && exc_q && store_q;
  assign io.rsp_rdata = rdata_q;
  assign io.bus_req = busy;
  assign io.bus_we = busy && store_q;
  assign io.bus_addr = busy ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
  assign io.bus_be = busy ? lane_be : '0;
  assign io.bus_wdata = busy ? lane_wdata : '0;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: 32- and 64-bit lsu_bus_ctrl instances checked against a per-access behavioural model
module tb_lsu_bus_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  lsu_bus_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
  lsu_bus_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if64 ();
  lsu_bus_ctrl #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .reset(reset), .io(if32));
  lsu_bus_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .reset(reset), .io(if64));
  logic sel64 = 1'b0, req_valid = 1'b0, req_store = 1'b0, req_sign = 1'b0, req_ovf = 1'b0;
  logic flush = 1'b0, bus_ack = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, bus_rdata = '0;
  assign if32.req_valid = req_valid & !sel64;
  assign if64.req_valid = req_valid & sel64;
  assign if32.flush = flush & !sel64;
  assign if64.flush = flush & sel64;
  assign if32.bus_ack = bus_ack & !sel64;
  assign if64.bus_ack = bus_ack & sel64;
  assign if32.req_store = req_store;
  assign if64.req_store = req_store;
  assign if32.req_sign = req_sign;
  assign if64.req_sign = req_sign;
  assign if32.req_ovf = req_ovf;
  assign if64.req_ovf = req_ovf;
  assign if32.req_size = req_size;
  assign if64.req_size = req_size;
  assign if32.req_addr = req_addr;
  assign if64.req_addr = req_addr;
  assign if32.req_wdata = req_wdata[31:0];
  assign if64.req_wdata = req_wdata;
  assign if32.bus_rdata = bus_rdata[31:0];
  assign if64.bus_rdata = bus_rdata;
  logic o_stall, o_rsp, o_adel, o_ades, o_req, o_we;
  logic [7:0] o_be;
  logic [31:0] o_addr;
  logic [63:0] o_rdata, o_wdata;
  always_comb begin
    o_stall = sel64 ? if64.stall : if32.stall;
    o_rsp = sel64 ? if64.rsp_valid : if32.rsp_valid;
    o_adel = sel64 ? if64.exc_adel : if32.exc_adel;
    o_ades = sel64 ? if64.exc_ades : if32.exc_ades;
    o_req = sel64 ? if64.bus_req : if32.bus_req;
    o_we = sel64 ? if64.bus_we : if32.bus_we;
    o_be = sel64 ? if64.bus_be : {4'd0, if32.bus_be};
    o_addr = sel64 ? if64.bus_addr : if32.bus_addr;
    o_rdata = sel64 ? if64.rsp_rdata : {32'd0, if32.rsp_rdata};
    o_wdata = sel64 ? if64.bus_wdata : {32'd0, if32.bus_wdata};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access from accept (cycle 0) until it retires; ackc = bus-ack cycle, flc = flush cycle (-1 none)
  task automatic access(input bit w, input bit st, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [63:0] wd, input bit ov, input int ackc, input logic [63:0] rd, input int flc);
    int nb, n, off, last;
    bit in0, in1, flt, killed, busy_c, done_c;
    logic [63:0] wmask, ebe, ewd, erd, bytev;
    string t;
    nb = w ? 8 : 4;
    n = 1 << sz;
    off = a % nb;
    in0 = a >= 32'h7F00 && a < 32'h7F0C;
    in1 = a >= 32'h7F10 && a < 32'h7F1C;
    flt = (a % n != 0) || (sz == 3 && !w) || ov || !(a <= 32'h2FFF || in0 || in1)
       || ((in0 || in1) && n < 4) || (st && ((in0 && a >= 32'h7F08) || (in1 && a >= 32'h7F18)));
    wmask = w ? '1 : 64'hFFFF_FFFF;
    ebe = ((64'd1 << n) - 64'd1) << off;
    ewd = (wd << (8 * off)) & wmask;
    erd = '0;
    for (int i = 0; i < n; i++) begin
      bytev = (rd >> (8 * (off + i))) & 64'hFF;
      erd |= bytev << (8 * i);
    end
    if (sg && n < 8 && erd[8*n-1]) erd |= ~64'd0 << (8 * n);
    erd &= wmask;
    killed = !flt && flc >= 1 && flc <= ackc;
    last = flt ? 1 : ackc + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #2;
      if (c == 0) begin
        sel64 = w; req_valid = 1'b1; req_store = st; req_size = sz; req_sign = sg;
        req_addr = a; req_wdata = wd; req_ovf = ov;
      end
      if (flc >= 0 && c > flc) req_valid = 1'b0;
      flush = c == flc;
      bus_ack = !flt && c == ackc;
      bus_rdata = bus_ack ? rd : {$urandom, $urandom};
      #1;
      busy_c = !flt && c >= 1 && c <= ackc;
      done_c = (flt && c == 1) || (!flt && !killed && c == ackc + 1);
      t = $sformatf("w%0d a=%h sz%0d st%0d c%0d", w ? 64 : 32, a, sz, st, c);
      check({t, " bus_req"}, 64'(o_req), 64'(busy_c));
      check({t, " stall"}, 64'(o_stall), 64'(req_valid && !done_c && !flush));
      check({t, " rsp_valid"}, 64'(o_rsp), 64'(done_c && !flush));
      check({t, " exc_adel"}, 64'(o_adel), 64'(done_c && !flush && flt && !st));
      check({t, " exc_ades"}, 64'(o_ades), 64'(done_c && !flush && flt && st));
      if (busy_c) begin
        check({t, " bus_be"}, 64'(o_be), ebe);
        check({t, " bus_addr"}, 64'(o_addr), 64'(a - 32'(off)));
        check({t, " bus_we"}, 64'(o_we), 64'(st));
        if (st) check({t, " bus_wdata"}, o_wdata, ewd);
      end
      if (done_c && !flush && !flt && !st) check({t, " rsp_rdata"}, o_rdata, erd);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #2;
      req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    bit w;
    int ackc, flc;
    #3;
    check("rst bus_req32", 64'(if32.bus_req), 64'd0);
    check("rst rsp_valid32", 64'(if32.rsp_valid), 64'd0);
    check("rst bus_be64", 64'(if64.bus_be), 64'd0);
    check("rst rsp_rdata64", if64.rsp_rdata, 64'd0);
    check("rst stall64", 64'(if64.stall), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    access(0, 1, 2'd1, 0, 32'h0000_0102, 64'h1234, 0, 3, 64'd0, -1);
    access(1, 0, 2'd0, 1, 32'h0000_0007, 64'd0, 0, 1, 64'h8011_2233_4455_6677, -1);
    access(0, 0, 2'd2, 0, 32'h0000_0002, 64'd0, 0, 1, 64'd0, -1);
    access(0, 1, 2'd2, 0, 32'h0000_7F08, 64'h55, 0, 1, 64'd0, -1);
    access(0, 0, 2'd1, 0, 32'h0000_7F00, 64'd0, 0, 1, 64'd0, -1);
    access(0, 0, 2'd2, 0, 32'h0000_7F08, 64'd0, 0, 2, 64'hDEAD_BEEF, -1);
    access(1, 0, 2'd2, 1, 32'h0000_7F14, 64'd0, 0, 1, 64'h8765_4321_0000_0000, -1);
    access(0, 0, 2'd2, 0, 32'h0000_0200, 64'd0, 0, 4, 64'h0BAD_F00D, 2);
    access(1, 0, 2'd2, 0, 32'h0000_0040, 64'd0, 0, 2, 64'h1111_2222_3333_4444, 3);
    access(0, 1, 2'd3, 0, 32'h0000_0008, 64'd1, 0, 1, 64'd0, -1);
    access(1, 1, 2'd3, 0, 32'h0000_0008, 64'hA5A5_5A5A_0F0F_F0F0, 0, 2, 64'd0, -1);
    access(0, 0, 2'd2, 0, 32'h0000_0010, 64'd0, 1, 1, 64'd0, -1);
    access(0, 0, 2'd0, 0, 32'h0000_2FFF, 64'd0, 0, 1, 64'hFF00_0000, -1);
    access(0, 0, 2'd0, 0, 32'h0000_3000, 64'd0, 0, 1, 64'd0, -1);
    for (int it = 0; it < 300; it++) begin
      w = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1: a = $urandom_range(0, 32'h2FFF);
        2: a = 32'h7F00 + $urandom_range(0, 31);
        3: a = 32'h2FF0 + $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      ackc = $urandom_range(1, 5);
      flc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, ackc + 1) : -1;
      access(w, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             $urandom_range(0, 15) == 0, ackc, {$urandom, $urandom}, flc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    sel64 = 1'b0; req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h100; req_ovf = 1'b0;
    @(posedge clk);
    #2;
    check("rstbusy bus_req before", 64'(o_req), 64'd1);
    reset = 1'b1;
    #1;
    check("rstbusy bus_req after", 64'(o_req), 64'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
`ifdef LSU_TIMEOUT_EN
    @(posedge clk);
    #2;
    sel64 = 1'b0; req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_addr = 32'h104;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #3;
      check($sformatf("tmo bus_req c%0d", c), 64'(o_req), 64'(c <= 15));
      check($sformatf("tmo rsp_valid c%0d", c), 64'(o_rsp), 64'(c == 16));
      check($sformatf("tmo exc_ades c%0d", c), 64'(o_ades), 64'(c == 16));
    end
    idle(2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
